// File: rtl/mnoc_flit_pkg.sv
// Shared flit format, injector FSM encoding and sample-queue entry layout
// for the mesh sensor packet injector.
package mnoc_flit_pkg;

  localparam int unsigned FLIT_W    = 18;
  localparam int unsigned TYPE_W    = 2;
  localparam int unsigned PAYLOAD_W = 16;
  localparam int unsigned NODE_W    = 4;
  localparam int unsigned SEQ_W     = 8;
  localparam int unsigned ENTRY_W   = 32;

  localparam logic [TYPE_W-1:0] FLIT_HEAD = 2'b01;
  localparam logic [TYPE_W-1:0] FLIT_BODY = 2'b00;
  localparam logic [TYPE_W-1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {StIdle, StHead, StBody, StTail} inj_state_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] sample;
    logic [PAYLOAD_W-1:0] ts;
  } sample_entry_t;

  // A sample whose low nibble equals our own id is redirected to the neighbour id.
  function automatic logic [FLIT_W-1:0] make_head(input logic [PAYLOAD_W-1:0] sample,
                                                  input logic [NODE_W-1:0]    src,
                                                  input logic [SEQ_W-1:0]     seq);
    logic [NODE_W-1:0] dst;
    dst = (sample[NODE_W-1:0] == src) ? (sample[NODE_W-1:0] ^ 4'h1) : sample[NODE_W-1:0];
    return {FLIT_HEAD, src, dst, seq};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample queue; a push into a full queue is accepted when a pop
// happens in the same cycle.
module sample_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthC);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/sensor_packet_injector.sv
// Timestamps non-zero sensor samples, queues them and serialises each one as a
// head/body/tail packet toward the local router port.
module sensor_packet_injector
  import mnoc_flit_pkg::*;
#(
  parameter logic [3:0]  SRC_ID     = 4'd0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       priority_sensor,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [FLIT_W-1:0] flit_data,
  output logic              busy,
  output logic [7:0]        drop_count
);

  inj_state_e        state_q, state_d;
  sample_entry_t     pkt_q, pkt_d;
  sample_entry_t     fifo_wdata, fifo_rdata;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [15:0]       ts_q;
  logic [7:0]        drop_q;
  logic              capture, pop, fifo_full, fifo_empty, drop;

  assign capture    = enable && (priority_sensor != 16'h0000);
  assign fifo_wdata = '{sample: priority_sensor, ts: ts_q};
  assign drop       = capture && fifo_full && !pop;

  sample_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    seq_d   = seq_q;
    flit_d  = flit_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          pkt_d   = fifo_rdata;
          flit_d  = make_head(fifo_rdata.sample, SRC_ID, seq_q);
          state_d = StHead;
        end
      end
      StHead: begin
        if (flit_ready) begin
          flit_d  = {FLIT_BODY, pkt_q.sample};
          state_d = StBody;
        end
      end
      StBody: begin
        if (flit_ready) begin
          flit_d  = {FLIT_TAIL, pkt_q.ts};
          state_d = StTail;
        end
      end
      StTail: begin
        if (flit_ready) begin
          seq_d = seq_q + 8'd1;
          // Chain straight into the next packet so no bubble follows the tail.
          if (!fifo_empty) begin
            pop     = 1'b1;
            pkt_d   = fifo_rdata;
            flit_d  = make_head(fifo_rdata.sample, SRC_ID, seq_d);
            state_d = StHead;
          end else begin
            flit_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pkt_q   <= '0;
      flit_q  <= '0;
      seq_q   <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      flit_q  <= flit_d;
      seq_q   <= seq_d;
      ts_q    <= ts_q + 16'd1;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign flit_valid = (state_q != StIdle);
  assign flit_data  = flit_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign drop_count = drop_q;

endmodule
